// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: run enable in, raster position, sync pins and pixel strobes out.
interface vga_timing_gen_if #(parameter int XW = 10, parameter int YW = 10);
    logic          en;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          hsync;
    logic          vsync;
    logic          visible;
    logic          pix_tick;
    logic          line_start;
    logic          frame_start;
    modport master (input en, output x, y, hsync, vsync, visible, pix_tick, line_start, frame_start);
    modport slave  (output en, input x, y, hsync, vsync, visible, pix_tick, line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: prescaled VGA raster counters with registered sync, blanking and strobes.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIX_DIV   = 1,
    parameter int XW        = 10,
    parameter int YW        = 10
) (
    input logic              clk,
    input logic              nrst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int PW       = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PIX_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);

    generate
        if (PIX_DIV < 1 || (1 << XW) < H_TOTAL || (1 << YW) < V_TOTAL) begin : g_bad_params
            $error("vga_timing_gen: PIX_DIV < 1 or XW/YW too narrow for the raster totals");
        end
    endgenerate

    logic [PW-1:0] r_pre, w_pre_nx;
    logic [XW-1:0] r_x, w_x_nx;
    logic [YW-1:0] r_y, w_y_nx;
    logic          r_hs, r_vs, r_vis, r_tick, r_ls, r_fs;
    logic          w_adv, w_x_wrap, w_hs, w_vs, w_vis;

    // Decode from the next position so the registered sync/visible line up with x/y.
    always_comb begin
        w_adv    = bus.en && r_pre == PRE_LAST;
        w_x_wrap = w_adv && r_x == X_LAST;
        w_pre_nx = w_adv ? '0 : (bus.en ? r_pre + PW'(1) : r_pre);
        w_x_nx   = !w_adv ? r_x : (w_x_wrap ? '0 : r_x + XW'(1));
        w_y_nx   = !w_x_wrap ? r_y : (r_y == Y_LAST ? '0 : r_y + YW'(1));
        w_hs     = (int'(w_x_nx) >= HS_START && int'(w_x_nx) < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        w_vs     = (int'(w_y_nx) >= VS_START && int'(w_y_nx) < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        w_vis    = int'(w_x_nx) < H_VISIBLE && int'(w_y_nx) < V_VISIBLE;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pre  <= '0;
            r_x    <= X_LAST;
            r_y    <= Y_LAST;
            r_hs   <= ~HSYNC_POL;
            r_vs   <= ~VSYNC_POL;
            r_vis  <= 1'b0;
            r_tick <= 1'b0;
            r_ls   <= 1'b0;
            r_fs   <= 1'b0;
        end else begin
            r_pre  <= w_pre_nx;
            r_x    <= w_x_nx;
            r_y    <= w_y_nx;
            r_hs   <= w_hs;
            r_vs   <= w_vs;
            r_vis  <= w_vis;
            r_tick <= w_adv;
            r_ls   <= w_adv && w_x_nx == '0;
            r_fs   <= w_adv && w_x_nx == '0 && w_y_nx == '0;
        end
    end

    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.hsync       = r_hs;
    assign bus.vsync       = r_vs;
    assign bus.visible     = r_vis;
    assign bus.pix_tick    = r_tick;
    assign bus.line_start  = r_ls;
    assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on default 640x480 timing, a tiny PIX_DIV=3 raster
// and en gating with default timing at PIX_DIV=3.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic nrst_a = 1'b0, nrst_b = 1'b0, nrst_c = 1'b0;
    int   n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(10), .YW(10)) if_a ();
    vga_timing_gen_if #(.XW(4),  .YW(4))  if_b ();
    vga_timing_gen_if #(.XW(10), .YW(10)) if_c ();

    vga_timing_gen u_a (.clk(clk), .nrst(nrst_a), .bus(if_a));
    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .PIX_DIV(3), .XW(4), .YW(4)
    ) u_b (.clk(clk), .nrst(nrst_b), .bus(if_b));
    vga_timing_gen #(.PIX_DIV(3)) u_c (.clk(clk), .nrst(nrst_c), .bus(if_c));

    typedef struct {
        int e;
        int x, y, hs, vs, vis, tk, ls, fs;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic edge_a();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input int x, input int y, input int hs, input int vs,
                         input int vis, input int tk, input int ls, input int fs);
        chk({tag, "_x"}, 32'(if_a.x), x);
        chk({tag, "_y"}, 32'(if_a.y), y);
        chk({tag, "_hs"}, 32'(if_a.hsync), hs);
        chk({tag, "_vs"}, 32'(if_a.vsync), vs);
        chk({tag, "_vis"}, 32'(if_a.visible), vis);
        chk({tag, "_tick"}, 32'(if_a.pix_tick), tk);
        chk({tag, "_ls"}, 32'(if_a.line_start), ls);
        chk({tag, "_fs"}, 32'(if_a.frame_start), fs);
    endtask

    initial begin
        int cyc, pos_bad, hs_bad, vis_bad, tick_bad, hs_low, ls_cnt, ls_at, fs_cnt;
        int ex, ey;
        string tag;
        if_a.en = 1'b0;
        if_b.en = 1'b0;
        if_c.en = 1'b0;

        // ---- Default timing, PIX_DIV=1 ----
        repeat (2) @(negedge clk);
        chk_a("a_rst", 799, 524, 1, 1, 0, 0, 0, 0);
        if_a.en = 1'b1;
        nrst_a  = 1'b1;
        edge_a();
        chk_a("a_e1", 0, 0, 1, 1, 1, 1, 1, 1);
        pos_bad = 0; hs_bad = 0; vis_bad = 0; tick_bad = 0;
        hs_low = 0; ls_cnt = 0; ls_at = 0; fs_cnt = 0;
        for (int k = 2; k <= 801; k++) begin
            edge_a();
            ex = (k - 1) % 800;
            ey = (k == 801) ? 1 : 0;
            if (int'(if_a.x) != ex || int'(if_a.y) != ey) pos_bad++;
            if (if_a.hsync !== ((ex >= 656 && ex < 752) ? 1'b0 : 1'b1)) hs_bad++;
            if (if_a.hsync === 1'b0) hs_low++;
            if (if_a.visible !== (ex < 640 ? 1'b1 : 1'b0)) vis_bad++;
            if (if_a.pix_tick !== 1'b1) tick_bad++;
            if (if_a.line_start === 1'b1) begin ls_cnt++; ls_at = k; end
            if (if_a.frame_start === 1'b1) fs_cnt++;
        end
        chk("a_line_pos_errors", pos_bad, 0);
        chk("a_hsync_window_errors", hs_bad, 0);
        chk("a_hsync_low_clks", hs_low, 96);
        chk("a_visible_errors", vis_bad, 0);
        chk("a_tick_errors", tick_bad, 0);
        chk("a_line_start_count", ls_cnt, 1);
        chk("a_line_period", ls_at - 1, 800);
        chk("a_frame_start_count", fs_cnt, 0);
        for (int k = 802; k <= 1101; k++) edge_a();
        chk_a("a_300_1", 300, 1, 1, 1, 1, 1, 0, 0);
        // async reset between edges: outputs must drop before the next posedge
        #2 nrst_a = 1'b0;
        #1 chk_a("a_async_rst", 799, 524, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        nrst_a = 1'b1;
        edge_a();
        chk_a("a_restart", 0, 0, 1, 1, 1, 1, 1, 1);
        if_a.en = 1'b0;

        // ---- Small raster, PIX_DIV=3: advances land on edges 3,6,9,... ----
        tbl.push_back('{3,   0, 0, 1, 1, 1, 1, 1, 1});
        tbl.push_back('{4,   0, 0, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{5,   0, 0, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{6,   1, 0, 1, 1, 1, 1, 0, 0});
        tbl.push_back('{7,   1, 0, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{15,  4, 0, 1, 1, 0, 1, 0, 0});
        tbl.push_back('{18,  5, 0, 0, 1, 0, 1, 0, 0});
        tbl.push_back('{21,  6, 0, 0, 1, 0, 1, 0, 0});
        tbl.push_back('{24,  7, 0, 1, 1, 0, 1, 0, 0});
        tbl.push_back('{27,  0, 1, 1, 1, 1, 1, 1, 0});
        tbl.push_back('{28,  0, 1, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{60,  3, 2, 1, 1, 1, 1, 0, 0});
        tbl.push_back('{99,  0, 4, 1, 0, 0, 1, 1, 0});
        tbl.push_back('{100, 0, 4, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{123, 0, 5, 1, 1, 0, 1, 1, 0});
        tbl.push_back('{144, 7, 5, 1, 1, 0, 1, 0, 0});
        tbl.push_back('{146, 7, 5, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{147, 0, 0, 1, 1, 1, 1, 1, 1});
        tbl.push_back('{148, 0, 0, 1, 1, 1, 0, 0, 0});
        @(negedge clk);
        chk("b_rst_x", 32'(if_b.x), 7);
        chk("b_rst_y", 32'(if_b.y), 5);
        if_b.en = 1'b1;
        nrst_b  = 1'b1;
        cyc = 0;
        foreach (tbl[i]) begin
            while (cyc < tbl[i].e) begin
                @(posedge clk);
                cyc++;
            end
            @(negedge clk);
            tag = $sformatf("b_e%0d", tbl[i].e);
            chk({tag, "_x"}, 32'(if_b.x), tbl[i].x);
            chk({tag, "_y"}, 32'(if_b.y), tbl[i].y);
            chk({tag, "_hs"}, 32'(if_b.hsync), tbl[i].hs);
            chk({tag, "_vs"}, 32'(if_b.vsync), tbl[i].vs);
            chk({tag, "_vis"}, 32'(if_b.visible), tbl[i].vis);
            chk({tag, "_tick"}, 32'(if_b.pix_tick), tbl[i].tk);
            chk({tag, "_ls"}, 32'(if_b.line_start), tbl[i].ls);
            chk({tag, "_fs"}, 32'(if_b.frame_start), tbl[i].fs);
        end
        if_b.en = 1'b0;

        // ---- en gating, default raster at PIX_DIV=3: x=100 lands on edge 303 ----
        @(negedge clk);
        if_c.en = 1'b1;
        nrst_c  = 1'b1;
        for (int k = 1; k <= 304; k++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("c_e304_x", 32'(if_c.x), 100);
        chk("c_e304_tick", 32'(if_c.pix_tick), 0);
        if_c.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            tag = $sformatf("c_hold%0d", k);
            chk({tag, "_x"}, 32'(if_c.x), 100);
            chk({tag, "_y"}, 32'(if_c.y), 0);
            chk({tag, "_hs"}, 32'(if_c.hsync), 1);
            chk({tag, "_vs"}, 32'(if_c.vsync), 1);
            chk({tag, "_vis"}, 32'(if_c.visible), 1);
            chk({tag, "_tick"}, 32'(if_c.pix_tick), 0);
        end
        if_c.en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("c_resume1_x", 32'(if_c.x), 100);
        chk("c_resume1_tick", 32'(if_c.pix_tick), 0);
        @(posedge clk);
        @(negedge clk);
        chk("c_resume2_x", 32'(if_c.x), 101);
        chk("c_resume2_tick", 32'(if_c.pix_tick), 1);
        chk("c_resume2_ls", 32'(if_c.line_start), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
